// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, baud divider computation and
// parity helper. Used by both the receive and transmit paths.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    // Clocks per oversample tick, integer floor.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    // Parity bit that makes the frame's total ones count even (odd=0) or odd (odd=1).
    // Data is zero-extended by the caller, so padding bits do not affect the result.
    function automatic logic parity_bit(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks.
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == '0);

    // Down-counter reloads on terminal count; the tick fires on the terminal count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx_in, deframes start/data/(parity)/stop using
// an oversample tick, and emits a one-cycle FIFO write or a one-cycle error pulse.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | line idle, waiting for a falling edge
//  START  | counting to mid start bit; high there means glitch
//  DATA   | sampling data bits at mid-bit, LSB first
//  PARITY | sampling parity bit, latching mismatch
//  STOP   | sampling stop bit, issuing write or a single error pulse
//  BREAK  | stop bit was low; wait for line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_in,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);
    localparam logic [2:0]    ST_AFTER_DATA = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;

    logic                  tick;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  rx_s_d;
    logic                  rx_fall;
    logic [2:0]            state;
    logic [SW-1:0]         smp_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bad;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick)
    );

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; all idle high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign rx_fall = rx_s_d & ~rx_s;
    assign busy    = (state != ST_IDLE);

    // Frame FSM with sample counters, shift register and registered output pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            smp_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        state   <= ST_START;
                        smp_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (smp_cnt == SMP_MID) begin
                            smp_cnt <= '0;
                            if (!rx_s) begin
                                state   <= ST_DATA;
                                bit_cnt <= '0;
                                par_bad <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt   <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= ST_AFTER_DATA;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt <= '0;
                            par_bad <= (rx_s != parity_bit(64'(shift_reg), ODD));
                            state   <= ST_STOP;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (smp_cnt == SMP_LAST) begin
                            smp_cnt <= '0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end else begin
                                state <= ST_IDLE;
                                if (par_bad) begin
                                    parity_err <= 1'b1;
                                end else if (fifo_full) begin
                                    overrun <= 1'b1;
                                end else begin
                                    wr_en   <= 1'b1;
                                    wr_data <= shift_reg;
                                end
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
